// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, inverse-round FSM encoding and the FIPS-197 inverse S-box.
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [AES_BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: combinational FIPS-197 inverse S-box byte lookup.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] a,
  output logic [AES_BYTE_W-1:0] y
);
  assign y = INV_SBOX[a];
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative InvSubBytes, LANES bytes per clock with valid/ready on both sides.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);
  localparam int N = 16 / LANES;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int LW = AES_BYTE_W * LANES;
  state_t state, state_nxt;
  logic [AES_STATE_W-1:0] work, rot;
  logic [AES_STATE_W+LW-1:0] cat;
  logic [LW-1:0] sub;
  logic [CW-1:0] cnt;
  logic last;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox u_sbox (
      .a(work[AES_STATE_W-1-AES_BYTE_W*g -: AES_BYTE_W]),
      .y(sub[LW-1-AES_BYTE_W*g -: AES_BYTE_W])
    );
  end
  // rotating left while refilling at the LSB end restores byte order after N steps
  assign cat = {work, sub};
  assign rot = cat[AES_STATE_W-1:0];
  assign last = cnt == CW'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready = state == IDLE;
    busy = state == RUN || state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      work <= '0;
      cnt <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      work <= in_state;
      cnt <= '0;
    end else if (state == RUN) begin
      work <= rot;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
        out_state <= rot;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed and random checks against a GF(2^8) arithmetic model of InvSubBytes.
module tb_inv_sub_bytes_seq;
  localparam logic [127:0] C1_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam int LV [4] = '{1, 2, 8, 16};
  logic clk = 1'b0, rst = 1'b1;
  logic iv = 1'b0, ordy = 1'b1, ir, ov, bsy;
  logic [127:0] st = '0, os;
  logic sv = 1'b0;
  logic sw_ir [4], sw_ov [4], sw_busy [4];
  logic [127:0] sw_os [4];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_state(st),
    .out_valid(ov), .out_ready(ordy), .out_state(os), .busy(bsy)
  );
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    inv_sub_bytes_seq #(.LANES(LV[g])) u_sw (
      .clk(clk), .rst(rst), .in_valid(sv), .in_ready(sw_ir[g]), .in_state(st),
      .out_valid(sw_ov[g]), .out_ready(1'b1), .out_state(sw_os[g]), .busy(sw_busy[g])
    );
  end

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(logic [7:0] x);
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) return 8'(i);
    return 8'h00;
  endfunction
  function automatic logic [7:0] rotl(logic [7:0] y, int n);
    return (y << n) | (y >> (8 - n));
  endfunction
  // InvSbox(y) = inverse of the inverse affine transform of y
  function automatic logic [7:0] ref_byte(logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction
  function automatic logic [127:0] ref_block(logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_byte(s[127-8*i -: 8]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_block(input string tag, input logic [127:0] d, output logic [127:0] res, output int lat);
    iv = 1'b1;
    st = d;
    step();
    iv = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ov && lat < 40);
    res = os;
  endtask

  initial begin
    logic [127:0] r, d, held;
    logic [127:0] got [$];
    int lat, acc [$], sw_lat [4];
    logic [127:0] sw_res [4];
    logic pre;
    step();
    check("reset_out_valid", 128'(ov), 128'(0));
    check("reset_out_state", os, '0);
    check("reset_in_ready", 128'(ir), 128'(1));
    check("reset_busy", 128'(bsy), 128'(0));
    rst = 1'b0;
    step();
    run_block("c1", C1_IN, r, lat);
    check("c1_result", r, C1_OUT);
    check("c1_model", r, ref_block(C1_IN));
    check("c1_latency", 128'(lat), 128'(4));
    step();
    check("c1_valid_one_cycle", 128'(ov), 128'(0));
    check("c1_in_ready_after", 128'(ir), 128'(1));
    run_block("zeros", '0, r, lat);
    check("all00", r, {16{8'h52}});
    step();
    run_block("sixty3", {16{8'h63}}, r, lat);
    check("all63", r, '0);
    step();
    run_block("ff", {16{8'hff}}, r, lat);
    check("allff", r, {16{8'h7d}});
    step();
    d = 128'h0102030405060708090a0b0c0d0e0f10;
    run_block("seq", d, r, lat);
    check("seq_byte0", 128'(r[127:120]), 128'(8'h09));
    check("seq_model", r, ref_block(d));
    step();
    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block("rand", d, r, lat);
      check("rand_result", r, ref_block(d));
      check("rand_latency", 128'(lat), 128'(4));
      step();
    end
    ordy = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    run_block("bp", d, held, lat);
    check("bp_result", held, ref_block(d));
    for (int k = 0; k < 10; k++) begin
      iv = k == 3;
      st = ~d;
      step();
      check("bp_hold_valid", 128'(ov), 128'(1));
      check("bp_hold_state", os, held);
      check("bp_in_ready", 128'(ir), 128'(0));
    end
    iv = 1'b0;
    ordy = 1'b1;
    step();
    check("bp_release_valid", 128'(ov), 128'(0));
    check("bp_release_ready", 128'(ir), 128'(1));
    for (int k = 0; k < 6; k++) step();
    check("bp_pulse_ignored", 128'(ov | bsy), 128'(0));
    d = {$urandom, $urandom, $urandom, $urandom};
    r = {$urandom, $urandom, $urandom, $urandom};
    iv = 1'b1;
    st = d;
    for (int e = 0; e < 20; e++) begin
      pre = ir && iv;
      step();
      if (pre) begin
        acc.push_back(e);
        if (acc.size() == 1) st = r;
        else iv = 1'b0;
      end
      if (ov) got.push_back(os);
    end
    iv = 1'b0;
    check("b2b_accepts", 128'(acc.size()), 128'(2));
    check("b2b_results", 128'(got.size()), 128'(2));
    if (acc.size() == 2) check("b2b_spacing", 128'(acc[1] - acc[0]), 128'(6));
    if (got.size() == 2) begin
      check("b2b_first", got[0], ref_block(d));
      check("b2b_second", got[1], ref_block(r));
    end
    check("pre_reset_state_nonzero", 128'(os != '0), 128'(1));
    iv = 1'b1;
    st = C1_IN;
    step();
    iv = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 128'(ov), 128'(0));
    check("rst_mid_state", os, '0);
    check("rst_mid_ready", 128'(ir), 128'(1));
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("rst_no_partial", 128'(ov), 128'(0));
    check("rst_state_zero", os, '0);
    d = {$urandom, $urandom, $urandom, $urandom};
    run_block("post_rst", d, r, lat);
    check("post_rst_result", r, ref_block(d));
    step();
    for (int g = 0; g < 4; g++) begin
      sw_lat[g] = 0;
      sw_res[g] = '0;
    end
    sv = 1'b1;
    st = C1_IN;
    step();
    sv = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      step();
      for (int g = 0; g < 4; g++)
        if (sw_ov[g] && sw_lat[g] == 0) begin
          sw_lat[g] = c;
          sw_res[g] = sw_os[g];
        end
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("sweep_result_lanes%0d", LV[g]), sw_res[g], C1_OUT);
      check($sformatf("sweep_latency_lanes%0d", LV[g]), 128'(sw_lat[g]), 128'(16 / LV[g]));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
